multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Purpose: control unit for a small multi-cycle processor. Walks each
// instruction through FETCH -> EXEC (-> MEM for loads/stores). It produces
// the datapath strobes, the PC update select, the Z/N flags and the
// return-address stack occupancy. A stack overflow or underflow, or an
// illegal opcode, latches a sticky fault and parks the controller in HALT
// until the next reset.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   run        in   start / continue execution
//   op         in   opcode held in the instruction register (OP_W bits)
//   cond       in   op10 condition select: 0 = branch on Z, 1 = branch on N
//   port_idx   in   input-port field of the instruction (PORT_W bits)
//   alu_z      in   ALU zero result
//   alu_n      in   ALU negative result
//   mem_ack    in   memory completes the outstanding request this cycle
//   mem_req    out  memory request (fetch, load or store)
//   ir_we      out  instruction register load
//   pc_we      out  PC update
//   branchSel  out  PC source: 0 = pc+2, 1 = target, 2 = stack top
//   rfwe       out  {LR push, N we, Z we, RF we}
//   dmwe       out  data memory write
//   outwe      out  output port write
//   wbSel      out  register-file write-back select
//   portSel    out  selected input port (PORT_W bits)
//   sp         out  stack occupancy
//   z_flag     out  registered zero flag
//   n_flag     out  registered negative flag
//   fault      out  sticky fault

module multicycle_controller #(
  parameter int OP_W      = 4,
  parameter int PORT_W    = 2,
  parameter int STK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           run,
  input  logic [OP_W-1:0]                op,
  input  logic                           cond,
  input  logic [PORT_W-1:0]              port_idx,
  input  logic                           alu_z,
  input  logic                           alu_n,
  input  logic                           mem_ack,
  output logic                           mem_req,
  output logic                           ir_we,
  output logic                           pc_we,
  output logic [1:0]                     branchSel,
  output logic [3:0]                     rfwe,
  output logic                           dmwe,
  output logic                           outwe,
  output logic                           wbSel,
  output logic [PORT_W-1:0]              portSel,
  output logic [$clog2(STK_DEPTH):0]     sp,
  output logic                           z_flag,
  output logic                           n_flag,
  output logic                           fault
);

  localparam int SP_W = $clog2(STK_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t          state_q;
  logic [SP_W-1:0] sp_q;
  logic            z_q;
  logic            n_q;
  logic            fault_q;

  // ---------------------------------------------------------------------
  // Opcode decode. The opcode is widened so that codes 16 and above can be
  // recognised for any OP_W, while the low nibble selects the operation.
  // ---------------------------------------------------------------------
  logic [31:0] op_ext;
  logic [3:0]  opc;
  logic        op_illegal;
  logic        stk_full;
  logic        stk_empty;
  logic        exec_fault;
  logic        is_mem_op;
  logic        take_br;

  always_comb begin
    op_ext     = 32'(op);
    opc        = op_ext[3:0];
    op_illegal = (op_ext > 32'd15);
    stk_full   = (sp_q == SP_W'(STK_DEPTH));
    stk_empty  = (sp_q == '0);
    exec_fault = op_illegal
               | ((opc == 4'd11) & stk_full)
               | ((opc == 4'd12) & stk_empty);
    is_mem_op  = !op_illegal && ((opc == 4'd13) || (opc == 4'd14));
    // Flags are read from the registers, so an op10 directly after an ALU
    // op sees the values loaded at the end of that ALU op's EXEC cycle.
    take_br    = cond ? n_q : z_q;
  end

  // ---------------------------------------------------------------------
  // State machine, stack pointer, flags and fault.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ack) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_fault) begin
            fault_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            if ((opc >= 4'd1) && (opc <= 4'd3)) begin
              z_q <= alu_z;
              n_q <= alu_n;
            end
            if (opc == 4'd11) sp_q <= sp_q + SP_W'(1);
            if (opc == 4'd12) sp_q <= sp_q - SP_W'(1);
            if (is_mem_op)  state_q <= S_MEM;
            else if (run)   state_q <= S_FETCH;
            else            state_q <= S_IDLE;
          end
        end
        S_MEM: begin
          if (mem_ack) state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output decode from the registered state. mem_req depends on state only,
  // so there is no path from mem_ack to mem_req, and an asynchronous reset
  // drops it at once. The ack-cycle strobes (ir_we, MEM completion) are
  // qualified by mem_ack because they must fire in the acknowledging cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_req   = (state_q == S_FETCH) || (state_q == S_MEM);
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    branchSel = 2'd0;
    rfwe      = 4'b0000;
    dmwe      = 1'b0;
    outwe     = 1'b0;
    wbSel     = 1'b0;
    portSel   = '0;

    case (state_q)
      S_FETCH: begin
        ir_we = mem_ack;
      end
      S_EXEC: begin
        if (!exec_fault) begin
          case (opc)
            4'd1, 4'd2, 4'd3: rfwe = 4'b0111;
            4'd4, 4'd5, 4'd8: rfwe = 4'b0001;
            4'd6:             outwe = 1'b1;
            4'd7: begin
              rfwe    = 4'b0001;
              portSel = port_idx;
            end
            4'd11:            rfwe = 4'b1000;
            4'd15: begin
              rfwe  = 4'b0001;
              wbSel = 1'b1;
            end
            default: ;
          endcase
          // Loads and stores update the PC when memory acknowledges.
          if (!is_mem_op) begin
            pc_we = 1'b1;
            case (opc)
              4'd9, 4'd11: branchSel = 2'd1;
              4'd10:       branchSel = take_br ? 2'd1 : 2'd0;
              4'd12:       branchSel = 2'd2;
              default:     branchSel = 2'd0;
            endcase
          end
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          pc_we = 1'b1;
          if (opc == 4'd14) dmwe = 1'b1;
          if (opc == 4'd13) begin
            rfwe  = 4'b0001;
            wbSel = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign sp     = sp_q;
  assign z_flag = z_q;
  assign n_flag = n_q;
  assign fault  = fault_q;

endmodule
